axi_burst_rw_checker: RTL and testbench

- Parametrised successor to the single-beat AXI write poker on the DDR test path.
- Writes NUM_BURSTS incrementing bursts of BURST_LEN beats from BASE_ADDR, waits for each write response, then reads the same region back and compares every beat.
- Reports busy/done/pass and an error count.
- Sits between the test controller (or free-running timer) and one AXI master port of the DDR controller.

---
 rtl/axi_burst_rw_checker.sv | 191 +++++++++++++++++++
 tb/tb_axi_burst_rw_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_rw_checker.sv
// AXI burst write/read-back checker: writes NUM_BURSTS incrementing bursts, reads them back,
// compares every beat and reports busy/done/pass plus a saturating error count.
module axi_burst_rw_checker #(
    parameter int unsigned    DW         = 64,
    parameter int unsigned    AW         = 32,
    parameter int unsigned    BURST_LEN  = 16,
    parameter int unsigned    NUM_BURSTS = 8,
    parameter logic [AW-1:0]  BASE_ADDR  = 32'h0800_0000,
    parameter logic [31:0]    PATTERN    = 32'h1414_4141,
    parameter int unsigned    PERIOD     = 300
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] awaddr,
    output logic [7:0]    awlen,
    output logic          awvalid,
    input  logic          awready,
    output logic [DW-1:0] wdata,
    output logic          wlast,
    output logic          wvalid,
    input  logic          wready,
    input  logic [1:0]    bresp,
    input  logic          bvalid,
    output logic          bready,
    output logic [AW-1:0] araddr,
    output logic [7:0]    arlen,
    output logic          arvalid,
    input  logic          arready,
    input  logic [DW-1:0] rdata,
    input  logic          rlast,
    input  logic          rvalid,
    output logic          rready,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_cnt
);

    localparam int unsigned StrideBytes = BURST_LEN * (DW / 8);
    localparam logic [7:0]  LastBeat    = 8'(BURST_LEN - 1);
    localparam logic [15:0] LastBurst   = 16'(NUM_BURSTS - 1);
    localparam logic [31:0] PeriodLast  = 32'(PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle, StWaddr, StWdata, StWresp, StRaddr, StRdata, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   burst_q, burst_d;
    logic [7:0]    beat_q, beat_d;
    logic [15:0]   err_q, err_d;
    logic          pass_q, pass_d;
    logic [31:0]   per_q, per_d;

    logic          period_hit;
    logic          last_beat;
    logic [15:0]   word_idx;
    logic [31:0]   exp_word;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] burst_addr;
    logic          data_err;
    logic          last_err;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign period_hit = (PERIOD != 0) && (per_q == PeriodLast);
    assign last_beat  = (beat_q == LastBeat);
    assign word_idx   = burst_q * 16'(BURST_LEN) + {8'd0, beat_q};
    assign exp_word   = PATTERN + {16'd0, word_idx};
    assign exp_data   = {(DW / 32){exp_word}};
    assign burst_addr = BASE_ADDR + AW'(burst_q) * AW'(StrideBytes);
    assign data_err   = (rdata != exp_data);
    assign last_err   = (rlast != last_beat);

    // Outputs decode straight from state so an async reset clears them in the same cycle.
    assign awvalid = (state_q == StWaddr);
    assign awaddr  = awvalid ? burst_addr : '0;
    assign awlen   = LastBeat;
    assign wvalid  = (state_q == StWdata);
    assign wdata   = wvalid ? exp_data : '0;
    assign wlast   = wvalid && last_beat;
    assign bready  = (state_q == StWresp);
    assign arvalid = (state_q == StRaddr);
    assign araddr  = arvalid ? burst_addr : '0;
    assign arlen   = LastBeat;
    assign rready  = (state_q == StRdata);
    assign busy    = (state_q != StIdle) && (state_q != StDone);
    assign done    = (state_q == StDone);
    assign pass    = done ? (err_q == 16'd0) : pass_q;
    assign err_cnt = err_q;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        err_d   = err_q;
        pass_d  = pass_q;
        per_d   = period_hit ? 32'd0 : per_q + 32'd1;
        unique case (state_q)
            StIdle: begin
                if (start || period_hit) begin
                    burst_d = '0;
                    beat_d  = '0;
                    err_d   = '0;
                    state_d = StWaddr;
                end
            end
            StWaddr: begin
                if (awready) begin
                    beat_d  = '0;
                    state_d = StWdata;
                end
            end
            StWdata: begin
                if (wready) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = StWresp;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StWresp: begin
                if (bvalid) begin
                    if (bresp != 2'b00) err_d = sat_add(err_q, 2'd1);
                    if (burst_q == LastBurst) begin
                        burst_d = '0;
                        state_d = StRaddr;
                    end else begin
                        burst_d = burst_q + 16'd1;
                        state_d = StWaddr;
                    end
                end
            end
            StRaddr: begin
                if (arready) begin
                    beat_d  = '0;
                    state_d = StRdata;
                end
            end
            StRdata: begin
                if (rvalid) begin
                    // Data and framing errors on the same beat both count.
                    err_d = sat_add(err_q, {1'b0, data_err} + {1'b0, last_err});
                    if (last_beat || rlast) begin
                        beat_d = '0;
                        if (burst_q == LastBurst) begin
                            burst_d = '0;
                            state_d = StDone;
                        end else begin
                            burst_d = burst_q + 16'd1;
                            state_d = StRaddr;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StDone: begin
                pass_d  = (err_q == 16'd0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            per_q   <= per_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_rw_checker.sv
// Directed bench for axi_burst_rw_checker: a behavioural AXI slave with backpressure and
// fault-injection knobs, checked against hand-computed addresses, data and error counts.
module tb_axi_burst_rw_checker;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned BL = 4;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DW-1:0] wdata, rdata;
    logic [1:0]    bresp;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          busy, done, pass;
    logic [15:0]   err_cnt;

    always #5 clk = ~clk;

    axi_burst_rw_checker #(
        .DW(64), .AW(32), .BURST_LEN(4), .NUM_BURSTS(2),
        .BASE_ADDR(32'h0800_0000), .PATTERN(32'h1414_4141), .PERIOD(300)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
    );

    logic [63:0] exp_w [8] = '{
        64'h14144141_14144141, 64'h14144142_14144142, 64'h14144143_14144143,
        64'h14144144_14144144, 64'h14144145_14144145, 64'h14144146_14144146,
        64'h14144147_14144147, 64'h14144148_14144148
    };

    // Slave knobs, written by the main sequence only.
    logic bp_mode = 0, bresp_err = 0, corrupt = 0, early_last = 0;

    // Slave model state and logs, written by the slave process only.
    logic [DW-1:0] mem [16];
    logic [AW-1:0] aw_log[$], ar_log[$], aw_hold;
    logic [DW-1:0] w_log[$], w_hold;
    logic          w_last_log[$];
    int            done_stamp[$];
    int            cyc, aw_wait, aw_stall, w_base, w_beat, b_cnt, r_base, r_beat, r_cnt;
    logic          w_tog, b_pend, r_pend, aw_hold_v, w_hold_v, aw_unstable, w_unstable;

    int n_vec = 0;
    int n_bad = 0;

    function automatic int word_of(input logic [AW-1:0] a);
        return int'((a - 32'h0800_0000) >> 3);
    endfunction

    function automatic bit in_mem(input int i);
        return (i >= 0) && (i < 16);
    endfunction

    // Negedge slave: drive inputs from committed state, then commit the handshakes that the
    // following posedge will see.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = '0; rlast = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_log.delete(); ar_log.delete(); w_log.delete(); w_last_log.delete();
                done_stamp.delete();
                cyc = 0; aw_wait = 0; aw_stall = 0; w_base = 0; w_beat = 0; b_cnt = 0;
                r_base = 0; r_beat = 0; r_cnt = 0; w_tog = 0; b_pend = 0; r_pend = 0;
                aw_hold_v = 0; w_hold_v = 0; aw_unstable = 0; w_unstable = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rdata = '0; rlast = 0;
            end else begin
                cyc++;
                if (done) done_stamp.push_back(cyc);
                awready = bp_mode ? (aw_wait >= 5) : 1'b1;
                w_tog   = ~w_tog;
                wready  = bp_mode ? w_tog : 1'b1;
                bvalid  = b_pend;
                bresp   = (bresp_err && b_cnt == 0) ? 2'b10 : 2'b00;
                arready = 1'b1;
                rvalid  = r_pend;
                rdata   = (r_pend && in_mem(r_base + r_beat)) ? mem[r_base + r_beat] : '0;
                if (corrupt && r_cnt == 1 && r_beat == 2) rdata = rdata ^ 64'd1;
                rlast   = r_pend && ((r_beat == BL - 1) || (early_last && r_cnt == 0 && r_beat == 1));

                if (awvalid && !awready) begin
                    if (aw_hold_v && awaddr !== aw_hold) aw_unstable = 1;
                    aw_hold_v = 1; aw_hold = awaddr; aw_wait++; aw_stall++;
                end else begin
                    aw_hold_v = 0;
                end
                if (awvalid && awready) begin
                    aw_log.push_back(awaddr);
                    w_base = word_of(awaddr); w_beat = 0; aw_wait = 0;
                end
                if (wvalid && !wready) begin
                    if (w_hold_v && wdata !== w_hold) w_unstable = 1;
                    w_hold_v = 1; w_hold = wdata;
                end else begin
                    w_hold_v = 0;
                end
                if (wvalid && wready) begin
                    w_log.push_back(wdata);
                    w_last_log.push_back(wlast);
                    if (in_mem(w_base + w_beat)) mem[w_base + w_beat] = wdata;
                    w_beat++;
                    if (w_beat == BL) b_pend = 1;
                end
                if (bvalid && bready) begin
                    b_pend = 0; b_cnt++;
                end
                if (arvalid && arready) begin
                    ar_log.push_back(araddr);
                    r_base = word_of(araddr); r_beat = 0; r_pend = 1;
                end
                if (rvalid && rready) begin
                    if (rlast) begin
                        r_pend = 0; r_cnt++;
                    end else begin
                        r_beat++;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1; start = 0;
        repeat (3) @(negedge clk);
        rst = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string tag, input int max);
        bit ok;
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_done"}, 64'(ok), 64'd1);
    endtask

    task automatic check_write_logs(input string tag);
        logic [7:0] lastv;
        lastv = '0;
        check({tag, "_aw_n"}, 64'(aw_log.size()), 64'd2);
        check({tag, "_aw0"}, 64'((aw_log.size() > 0) ? aw_log[0] : '1), 64'h0800_0000);
        check({tag, "_aw1"}, 64'((aw_log.size() > 1) ? aw_log[1] : '1), 64'h0800_0020);
        check({tag, "_w_n"}, 64'(w_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_w%0d", tag, i), (i < w_log.size()) ? w_log[i] : '0, exp_w[i]);
            lastv[i] = (i < w_last_log.size()) ? w_last_log[i] : 1'b0;
        end
        check({tag, "_wlast"}, 64'(lastv), 64'h88);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1; start = 0;
        repeat (2) @(negedge clk);
        check("rst_ctl", 64'({awvalid, wvalid, wlast, bready, arvalid, rready, busy, done, pass,
                              err_cnt}), 64'd0);
        check("rst_addr", {awaddr, araddr}, 64'd0);
        check("rst_wdata", wdata, 64'd0);
        check("awlen", 64'({awlen, arlen}), 64'h0303);

        // Ideal slave
        do_reset();
        pulse_start();
        check("aw_latency", 64'({awvalid, busy, wvalid}), 64'b110);
        wait_done("ideal", 100);
        check("ideal_pass", 64'(pass), 64'd1);
        check("ideal_err", 64'(err_cnt), 64'd0);
        check("ideal_ar1", 64'((ar_log.size() > 1) ? ar_log[1] : '1), 64'h0800_0020);
        check_write_logs("ideal");
        @(negedge clk);
        check("ideal_idle", 64'({busy, done, pass}), 64'b001);

        // Backpressure
        do_reset();
        bp_mode = 1;
        pulse_start();
        wait_done("bp", 300);
        check("bp_pass", 64'({pass, err_cnt}), 64'h1_0000);
        check_write_logs("bp");
        check("bp_aw_stall", 64'(aw_stall), 64'd10);
        check("bp_stable", 64'({aw_unstable, w_unstable}), 64'd0);
        bp_mode = 0;

        // Bad write response on burst 0 plus corrupted read beat 2 of burst 1
        do_reset();
        bresp_err = 1; corrupt = 1;
        pulse_start();
        wait_done("err", 100);
        check("err_cnt2", 64'(err_cnt), 64'd2);
        check("err_pass", 64'(pass), 64'd0);
        @(negedge clk);
        check("err_pass_hold", 64'({busy, pass}), 64'd0);
        bresp_err = 0; corrupt = 0;

        // Early rlast on beat 1 of read burst 0
        do_reset();
        early_last = 1;
        pulse_start();
        wait_done("early", 100);
        check("early_err", 64'({pass, err_cnt}), 64'h0_0001);
        check("early_ar_n", 64'(ar_log.size()), 64'd2);
        check("early_ar1", 64'((ar_log.size() > 1) ? ar_log[1] : '1), 64'h0800_0020);
        early_last = 0;

        // Reset while beat 2 of the first write burst is presented
        do_reset();
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (wvalid && wdata == exp_w[2]) break;
            @(negedge clk);
        end
        check("mid_beat2", wdata, exp_w[2]);
        rst = 1;
        #1;
        check("mid_rst_ctl", 64'({awvalid, wvalid, wlast, bready, arvalid, rready, busy, done,
                                  pass, err_cnt}), 64'd0);
        check("mid_rst_data", wdata | {awaddr, araddr}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("mid_idle", 64'(busy), 64'd0);
        pulse_start();
        wait_done("mid_rerun", 100);
        check("mid_rerun_pass", 64'({pass, err_cnt}), 64'h1_0000);

        // Free-running period trigger; a start while busy must not queue another pass
        begin
            bit poked;
            poked = 0;
            do_reset();
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                start = 0;
                if (busy && !poked) begin
                    start = 1;
                    poked = 1;
                end
            end
            start = 0;
            check("per_poked", 64'(poked), 64'd1);
            check("per_n_done", 64'(done_stamp.size()), 64'd3);
            check("per_gap1", 64'((done_stamp.size() > 1) ? done_stamp[1] - done_stamp[0] : 0),
                  64'd300);
            check("per_gap2", 64'((done_stamp.size() > 2) ? done_stamp[2] - done_stamp[1] : 0),
                  64'd300);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
